// File: rtl/warp_context_switch.sv
// Multi-warp context store with round-robin warp scheduler for one core.
// Define WARP_FIXED_PRIORITY_EN to select the lowest-index eligible warp instead of round-robin.
module warp_context_switch #(
    parameter int unsigned NUM_WARPS  = 4,
    parameter int unsigned PC_BITS    = 8,
    parameter int unsigned STATE_BITS = 3,
    localparam int unsigned WID       = $clog2(NUM_WARPS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_WARPS-1:0]  warp_start_i,
    input  logic [NUM_WARPS-1:0]  warp_reset_i,
    input  logic [NUM_WARPS-1:0]  warp_stall_i,
    input  logic                  yield_i,
    input  logic [PC_BITS-1:0]    save_pc_i,
    input  logic [STATE_BITS-1:0] save_state_i,
    input  logic                  save_mem_read_i,
    input  logic                  save_mem_write_i,
    input  logic                  save_done_i,
    output logic [WID-1:0]        active_warp_o,
    output logic                  active_valid_o,
    output logic [PC_BITS-1:0]    restore_pc_o,
    output logic [STATE_BITS-1:0] restore_state_o,
    output logic                  restore_mem_read_o,
    output logic                  restore_mem_write_o,
    output logic                  switch_done_o,
    output logic                  all_done_o
);

    localparam logic [STATE_BITS-1:0] DecodeState = STATE_BITS'(2);

    typedef enum logic [1:0] {StIdle, StSelect, StRestore, StRun} fsm_e;

    fsm_e                  fsm_q, fsm_d;
    logic [WID-1:0]        active_q, active_d;
    logic [PC_BITS-1:0]    pc_q [NUM_WARPS];
    logic [PC_BITS-1:0]    pc_d [NUM_WARPS];
    logic [STATE_BITS-1:0] st_q [NUM_WARPS];
    logic [STATE_BITS-1:0] st_d [NUM_WARPS];
    logic [NUM_WARPS-1:0]  rd_q, rd_d, wr_q, wr_d, done_q, done_d, launched_q, launched_d;
    logic [PC_BITS-1:0]    restore_pc_q;
    logic [STATE_BITS-1:0] restore_st_q;
    logic                  restore_rd_q, restore_wr_q;
    logic                  all_done_q, all_done_d;

    logic                  kill, save_en, found, load_restore;
    logic [WID-1:0]        sel_warp;
    logic [NUM_WARPS-1:0]  eligible;

    // The active warp is dropped without saving when its own warp_reset arrives.
    assign kill    = warp_reset_i[active_q] && (fsm_q == StRun || fsm_q == StRestore);
    assign save_en = (fsm_q == StRun) && yield_i && !warp_reset_i[active_q];

    always_comb begin
        pc_d       = pc_q;
        st_d       = st_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        done_d     = done_q;
        launched_d = launched_q;
        if (save_en) begin
            pc_d[active_q] = save_pc_i;
            st_d[active_q] = save_state_i;
            if (save_state_i == DecodeState) begin
                rd_d[active_q] = save_mem_read_i;
                wr_d[active_q] = save_mem_write_i;
            end
            if (save_done_i) begin
                done_d[active_q] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            if (warp_start_i[i]) begin
                pc_d[i]       = '0;
                st_d[i]       = '0;
                rd_d[i]       = 1'b0;
                wr_d[i]       = 1'b0;
                done_d[i]     = 1'b0;
                launched_d[i] = 1'b1;
            end
            if (warp_reset_i[i]) begin
                pc_d[i]       = '0;
                st_d[i]       = '0;
                rd_d[i]       = 1'b0;
                wr_d[i]       = 1'b0;
                done_d[i]     = 1'b0;
                launched_d[i] = 1'b0;
            end
        end
        all_done_d = (|launched_d) && ((launched_d & ~done_d) == '0);
    end

    // Next-state context feeds the search so same-cycle launches are visible.
    assign eligible = launched_d & ~done_d & ~warp_stall_i;

    always_comb begin
        found    = 1'b0;
        sel_warp = active_q;
`ifdef WARP_FIXED_PRIORITY_EN
        for (int i = int'(NUM_WARPS) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found    = 1'b1;
                sel_warp = WID'(i);
            end
        end
`else
        for (int unsigned k = 1; k <= NUM_WARPS; k++) begin
            int unsigned idx;
            idx = 32'(active_q) + k;
            if (idx >= NUM_WARPS) begin
                idx = idx - NUM_WARPS;
            end
            if (!found && eligible[idx[WID-1:0]]) begin
                found    = 1'b1;
                sel_warp = WID'(idx);
            end
        end
`endif
    end

    always_comb begin
        fsm_d        = fsm_q;
        active_d     = active_q;
        load_restore = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (|eligible) begin
                    fsm_d = StSelect;
                end
            end
            StSelect: begin
                if (found) begin
                    active_d     = sel_warp;
                    load_restore = 1'b1;
                    fsm_d        = StRestore;
                end else if ((launched_d & ~done_d) == '0) begin
                    fsm_d = StIdle;
                end
            end
            StRestore: fsm_d = kill ? StSelect : StRun;
            StRun: begin
                if (kill || yield_i) begin
                    fsm_d = StSelect;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q        <= StIdle;
            active_q     <= '0;
            pc_q         <= '{default: '0};
            st_q         <= '{default: '0};
            rd_q         <= '0;
            wr_q         <= '0;
            done_q       <= '0;
            launched_q   <= '0;
            restore_pc_q <= '0;
            restore_st_q <= '0;
            restore_rd_q <= 1'b0;
            restore_wr_q <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            active_q   <= active_d;
            pc_q       <= pc_d;
            st_q       <= st_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            launched_q <= launched_d;
            all_done_q <= all_done_d;
            if (load_restore) begin
                restore_pc_q <= pc_d[sel_warp];
                restore_st_q <= st_d[sel_warp];
                restore_rd_q <= rd_d[sel_warp];
                restore_wr_q <= wr_d[sel_warp];
            end
        end
    end

    assign active_warp_o       = active_q;
    assign active_valid_o      = (fsm_q == StRun);
    assign switch_done_o       = (fsm_q == StRestore);
    assign restore_pc_o        = restore_pc_q;
    assign restore_state_o     = restore_st_q;
    assign restore_mem_read_o  = restore_rd_q;
    assign restore_mem_write_o = restore_wr_q;
    assign all_done_o          = all_done_q;

endmodule
